// File: rtl/toy_mem_responder_if.sv
// Processor-side bus of the toy memory responder: request, multiplexed
// address/data input, read data and status outputs.
interface toy_mem_responder_if;
  logic       MEM_EN;
  logic       WRITE_EN;
  logic [7:0] D_IN;
  logic [7:0] D_OUT;
  logic       READY;
  logic       BUSY;
  logic [7:0] ACCESS_CNT;

  modport master (output MEM_EN, WRITE_EN, D_IN,
                  input  D_OUT, READY, BUSY, ACCESS_CNT);
  modport slave  (input  MEM_EN, WRITE_EN, D_IN,
                  output D_OUT, READY, BUSY, ACCESS_CNT);
endinterface

// File: rtl/toy_mem_responder.sv
// Byte-wide memory slave with programmable wait states. Address and write
// data share D_IN; READY is a one-cycle registered completion strobe.
module toy_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input logic              CLK,
  input logic              RESET,
  toy_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_DONE} state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [7:0]          dout_q, dout_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                mem_we;
  logic [7:0]          mem_q [2**ADDR_W];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.MEM_EN) begin
        addr_d  = bus.D_IN[ADDR_W-1:0];
        wr_d    = bus.WRITE_EN;
        wcnt_d  = WS;
        state_d = (WAIT_STATES == 0) ? S_DATA : S_WAIT;
      end
      // A dropped request during wait states abandons the access silently.
      S_WAIT: if (!bus.MEM_EN) state_d = S_IDLE;
        else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = S_DATA;
        end
      S_DATA: begin
        mem_we  = wr_q;
        if (!wr_q) dout_d = mem_q[addr_q];
        ready_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        state_d = S_DONE;
      end
      // Request must be seen low before another access can start.
      S_DONE: if (!bus.MEM_EN) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[addr_q] <= bus.D_IN;
  end

  assign bus.D_OUT      = dout_q;
  assign bus.READY      = ready_q;
  assign bus.BUSY       = (state_q != S_IDLE);
  assign bus.ACCESS_CNT = cnt_q;
endmodule

// File: tb/tb_toy_mem_responder.sv
// Directed bench: four responders (WS=1, WS=0, WS=3, ADDR_W=4) share clock
// and reset, each with its own bus driven from per-index arrays.
module tb_toy_mem_responder;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic       mem_en [4];
  logic       we     [4];
  logic [7:0] din    [4];
  logic [7:0] dout   [4];
  logic [7:0] cnt    [4];
  logic       ready  [4];
  logic       busy   [4];
  int checks = 0;
  int failures = 0;

  toy_mem_responder_if b0(), b1(), b2(), b3();

  toy_mem_responder #(.ADDR_W(8), .WAIT_STATES(1)) u_ws1 (.CLK(CLK), .RESET(RESET), .bus(b0));
  toy_mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (.CLK(CLK), .RESET(RESET), .bus(b1));
  toy_mem_responder #(.ADDR_W(8), .WAIT_STATES(3)) u_ws3 (.CLK(CLK), .RESET(RESET), .bus(b2));
  toy_mem_responder #(.ADDR_W(4), .WAIT_STATES(1)) u_a4  (.CLK(CLK), .RESET(RESET), .bus(b3));

  assign b0.MEM_EN = mem_en[0]; assign b0.WRITE_EN = we[0]; assign b0.D_IN = din[0];
  assign b1.MEM_EN = mem_en[1]; assign b1.WRITE_EN = we[1]; assign b1.D_IN = din[1];
  assign b2.MEM_EN = mem_en[2]; assign b2.WRITE_EN = we[2]; assign b2.D_IN = din[2];
  assign b3.MEM_EN = mem_en[3]; assign b3.WRITE_EN = we[3]; assign b3.D_IN = din[3];
  assign dout[0] = b0.D_OUT; assign ready[0] = b0.READY; assign busy[0] = b0.BUSY; assign cnt[0] = b0.ACCESS_CNT;
  assign dout[1] = b1.D_OUT; assign ready[1] = b1.READY; assign busy[1] = b1.BUSY; assign cnt[1] = b1.ACCESS_CNT;
  assign dout[2] = b2.D_OUT; assign ready[2] = b2.READY; assign busy[2] = b2.BUSY; assign cnt[2] = b2.ACCESS_CNT;
  assign dout[3] = b3.D_OUT; assign ready[3] = b3.READY; assign busy[3] = b3.BUSY; assign cnt[3] = b3.ACCESS_CNT;

  // Runs one access on responder i. rdy_edge is the edge index (address edge = 0)
  // after which READY was first seen; WRITE_EN is inverted after the address edge.
  task automatic access(input int i, input bit w, input logic [7:0] a, input logic [7:0] d,
                        input int hold, output int rdy_edge, output int rdy_cnt,
                        output bit busy_ok, output bit busy_after);
    mem_en[i] = 1'b1; we[i] = w; din[i] = a;
    rdy_edge = -1; rdy_cnt = 0; busy_ok = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge CLK); #1;
      din[i] = d; we[i] = ~w;
      if (busy[i] !== 1'b1) busy_ok = 1'b0;
      if (ready[i] === 1'b1) begin
        if (rdy_edge < 0) rdy_edge = e;
        rdy_cnt++;
      end
      if (rdy_edge >= 0 && e >= rdy_edge + 1 + hold) break;
    end
    mem_en[i] = 1'b0;
    @(posedge CLK); #1;
    busy_after = busy[i];
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
    checks++; if (dout[0] !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", dout[0]); end
    checks++; if (cnt[0] !== 8'h00) begin failures++; $display("FAIL rst_cnt got=%h exp=00", cnt[0]); end
    checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL rst_busy_ws3 got=%b exp=0", busy[2]); end
    @(posedge CLK); #1; RESET = 1'b1;
  endtask

  task automatic test_write_read();
    int re, rc; bit bo, ba;
    access(0, 1'b1, 8'h10, 8'h5A, 0, re, rc, bo, ba);
    checks++; if (re !== 2) begin failures++; $display("FAIL wr_ready_edge got=%0d exp=2", re); end
    checks++; if (rc !== 1) begin failures++; $display("FAIL wr_ready_cnt got=%0d exp=1", rc); end
    checks++; if (bo !== 1'b1) begin failures++; $display("FAIL wr_busy_held got=%b exp=1", bo); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL wr_busy_after got=%b exp=0", ba); end
    access(0, 1'b0, 8'h10, 8'h00, 0, re, rc, bo, ba);
    checks++; if (re !== 2) begin failures++; $display("FAIL rd_ready_edge got=%0d exp=2", re); end
    checks++; if (dout[0] !== 8'h5A) begin failures++; $display("FAIL rd_data got=%h exp=5a", dout[0]); end
    checks++; if (cnt[0] !== 8'd2) begin failures++; $display("FAIL wr_rd_cnt got=%0d exp=2", cnt[0]); end
  endtask

  task automatic test_reset_mid();
    int re, rc; bit bo, ba;
    mem_en[0] = 1'b1; we[0] = 1'b1; din[0] = 8'h10;
    @(posedge CLK); #1;
    din[0] = 8'hEE;
    RESET = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy[0]); end
    checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", ready[0]); end
    checks++; if (dout[0] !== 8'h00) begin failures++; $display("FAIL midrst_dout got=%h exp=00", dout[0]); end
    checks++; if (cnt[0] !== 8'h00) begin failures++; $display("FAIL midrst_cnt got=%h exp=00", cnt[0]); end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    mem_en[0] = 1'b0;
    RESET = 1'b1;
    access(0, 1'b0, 8'h10, 8'h00, 0, re, rc, bo, ba);
    checks++; if (dout[0] !== 8'h5A) begin failures++; $display("FAIL midrst_mem got=%h exp=5a", dout[0]); end
    checks++; if (re !== 2) begin failures++; $display("FAIL midrst_next_edge got=%0d exp=2", re); end
    checks++; if (cnt[0] !== 8'd1) begin failures++; $display("FAIL midrst_next_cnt got=%0d exp=1", cnt[0]); end
  endtask

  task automatic test_latency();
    int re, rc; bit bo, ba;
    access(1, 1'b1, 8'h44, 8'hC3, 0, re, rc, bo, ba);
    checks++; if (re !== 1) begin failures++; $display("FAIL ws0_wr_edge got=%0d exp=1", re); end
    access(1, 1'b0, 8'h44, 8'h00, 0, re, rc, bo, ba);
    checks++; if (re !== 1) begin failures++; $display("FAIL ws0_rd_edge got=%0d exp=1", re); end
    checks++; if (dout[1] !== 8'hC3) begin failures++; $display("FAIL ws0_rd_data got=%h exp=c3", dout[1]); end
    checks++; if (bo !== 1'b1 || ba !== 1'b0) begin failures++; $display("FAIL ws0_busy got=%b%b exp=10", bo, ba); end
    access(2, 1'b1, 8'h30, 8'h33, 0, re, rc, bo, ba);
    checks++; if (re !== 4) begin failures++; $display("FAIL ws3_wr_edge got=%0d exp=4", re); end
    access(2, 1'b0, 8'h30, 8'h00, 0, re, rc, bo, ba);
    checks++; if (re !== 4) begin failures++; $display("FAIL ws3_rd_edge got=%0d exp=4", re); end
    checks++; if (dout[2] !== 8'h33) begin failures++; $display("FAIL ws3_rd_data got=%h exp=33", dout[2]); end
    checks++; if (bo !== 1'b1 || ba !== 1'b0) begin failures++; $display("FAIL ws3_busy got=%b%b exp=10", bo, ba); end
  endtask

  task automatic test_abort();
    int re, rc, seen; bit bo, ba;
    access(2, 1'b1, 8'h20, 8'h11, 0, re, rc, bo, ba);
    checks++; if (dout[2] !== 8'h33) begin failures++; $display("FAIL dout_hold_wr got=%h exp=33", dout[2]); end
    seen = 0;
    mem_en[2] = 1'b1; we[2] = 1'b1; din[2] = 8'h20;
    @(posedge CLK); #1;
    din[2] = 8'hFF;
    if (ready[2] === 1'b1) seen++;
    @(posedge CLK); #1;
    if (ready[2] === 1'b1) seen++;
    mem_en[2] = 1'b0;
    @(posedge CLK); #1;
    checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy[2]); end
    for (int k = 0; k < 5; k++) begin
      if (ready[2] === 1'b1) seen++;
      @(posedge CLK); #1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_ready got=%0d exp=0", seen); end
    checks++; if (cnt[2] !== 8'd3) begin failures++; $display("FAIL abort_cnt got=%0d exp=3", cnt[2]); end
    checks++; if (dout[2] !== 8'h33) begin failures++; $display("FAIL abort_dout got=%h exp=33", dout[2]); end
    access(2, 1'b0, 8'h20, 8'h00, 0, re, rc, bo, ba);
    checks++; if (dout[2] !== 8'h11) begin failures++; $display("FAIL abort_mem got=%h exp=11", dout[2]); end
    checks++; if (cnt[2] !== 8'd4) begin failures++; $display("FAIL abort_cnt_after got=%0d exp=4", cnt[2]); end
  endtask

  task automatic test_held_wrap();
    int re, rc; bit bo, ba;
    access(0, 1'b0, 8'h10, 8'h00, 10, re, rc, bo, ba);
    checks++; if (rc !== 1) begin failures++; $display("FAIL held_ready_cnt got=%0d exp=1", rc); end
    checks++; if (bo !== 1'b1 || ba !== 1'b0) begin failures++; $display("FAIL held_busy got=%b%b exp=10", bo, ba); end
    checks++; if (cnt[0] !== 8'd2) begin failures++; $display("FAIL held_cnt got=%0d exp=2", cnt[0]); end
    for (int k = 0; k < 253; k++) access(0, 1'b0, 8'h10, 8'h00, 0, re, rc, bo, ba);
    checks++; if (cnt[0] !== 8'd255) begin failures++; $display("FAIL wrap_pre got=%0d exp=255", cnt[0]); end
    access(0, 1'b0, 8'h10, 8'h00, 0, re, rc, bo, ba);
    checks++; if (cnt[0] !== 8'd0) begin failures++; $display("FAIL wrap_cnt got=%0d exp=0", cnt[0]); end
  endtask

  task automatic test_alias();
    int re, rc; bit bo, ba;
    access(3, 1'b1, 8'h13, 8'hA5, 0, re, rc, bo, ba);
    access(3, 1'b0, 8'h03, 8'h00, 0, re, rc, bo, ba);
    checks++; if (dout[3] !== 8'hA5) begin failures++; $display("FAIL alias_data got=%h exp=a5", dout[3]); end
    checks++; if (cnt[3] !== 8'd2) begin failures++; $display("FAIL alias_cnt got=%0d exp=2", cnt[3]); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem_en[i] = 1'b0; we[i] = 1'b0; din[i] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_reset_mid();
    test_latency();
    test_abort();
    test_held_wrap();
    test_alias();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
